// File: rtl/coproc_host_driver_pkg.sv
// coproc_host_driver_pkg: shared states, command bytes and result size for the coprocessor host driver.
package coproc_host_driver_pkg;
  typedef enum logic [2:0] {IDLE, CMD_A, LOAD_A, CMD_B, LOAD_B, CMD_OP, RECV, FINISH} state_e;
  typedef enum logic [1:0] {LD_FETCH, LD_CAPT, LD_LO, LD_HI} ld_e;
  typedef enum logic [1:0] {SND_READY, SND_WAIT_HI, SND_WAIT_LO} snd_e;
  localparam logic [7:0] CMD_A_BYTE = 8'h01;
  localparam logic [7:0] CMD_B_BYTE = 8'h02;
  localparam logic [7:0] CMD_DOT = 8'h06;
  localparam logic [7:0] CMD_DIST = 8'h07;
  localparam int RESULT_BYTES = 4;
endpackage

// File: rtl/coproc_host_driver_if.sv
// coproc_host_driver_if: job control, vector memory, UART byte and result signals of the host driver.
interface coproc_host_driver_if;
  logic start, mode;
  logic vec_en, vec_sel;
  logic [9:0] vec_addr;
  logic [15:0] vec_data;
  logic [7:0] tx_data;
  logic tx_start, tx_busy;
  logic [7:0] rx_data;
  logic rx_ready;
  logic [31:0] result;
  logic busy, done, err_timeout;
  modport master (
    input start, mode, vec_data, tx_busy, rx_data, rx_ready,
    output vec_en, vec_sel, vec_addr, tx_data, tx_start, result, busy, done, err_timeout
  );
  modport slave (
    output start, mode, vec_data, tx_busy, rx_data, rx_ready,
    input vec_en, vec_sel, vec_addr, tx_data, tx_start, result, busy, done, err_timeout
  );
endinterface

// File: rtl/coproc_host_driver_uart_byte_sender.sv
// uart_byte_sender: one tx_start pulse per accepted byte; re-arms only after tx_busy is seen high then low.
module uart_byte_sender
  import coproc_host_driver_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       tx_busy_i,
  output logic       ack_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o
);
  snd_e st_q, st_d;
  logic start_q, start_d;
  logic [7:0] data_q, data_d;
  assign ack_o = st_q == SND_READY && req_i && !tx_busy_i;
  assign tx_start_o = start_q;
  assign tx_data_o = data_q;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st_q <= SND_READY;
      start_q <= 1'b0;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      start_q <= start_d;
      data_q <= data_d;
    end
  end
  always_comb begin
    start_d = ack_o;
    data_d = ack_o ? byte_i : data_q;
    st_d = st_q == SND_READY   ? (ack_o ? SND_WAIT_HI : SND_READY) :
           st_q == SND_WAIT_HI ? (tx_busy_i ? SND_WAIT_LO : SND_WAIT_HI) :
                                 (tx_busy_i ? SND_WAIT_LO : SND_READY);
  end
endmodule

// File: rtl/coproc_host_driver.sv
// coproc_host_driver: streams vectors A/B and an op command over UART, then assembles a 4-byte result.
// Define HOST_TIMEOUT_EN to enable the result-reception watchdog.
module coproc_host_driver
  import coproc_host_driver_pkg::*;
#(
  parameter int N = 1024,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic clk_sys,
  input logic reset,
  coproc_host_driver_if.master bus
);
  localparam logic [9:0] LAST = 10'(N - 1);
  if (N < 1 || N > 1024 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("coproc_host_driver: N must be 1..1024 and TIMEOUT_CYCLES positive");
  end
  state_e state_q, state_d;
  ld_e ph_q, ph_d;
  logic mode_q, mode_d;
  logic [9:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] result_q, result_d;
  logic [1:0] cnt_q, cnt_d;
  logic req, ack, load;
  logic [7:0] byte_s;
`ifdef HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d;
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
  assign load = state_q == LOAD_A || state_q == LOAD_B;
  assign req = state_q == CMD_A || state_q == CMD_B || state_q == CMD_OP || (load && (ph_q == LD_LO || ph_q == LD_HI));
  assign byte_s = state_q == CMD_A  ? CMD_A_BYTE :
                  state_q == CMD_B  ? CMD_B_BYTE :
                  state_q == CMD_OP ? (mode_q ? CMD_DIST : CMD_DOT) :
                  ph_q == LD_HI     ? data_q[15:8] : data_q[7:0];
  assign bus.vec_en = load && ph_q == LD_FETCH;
  assign bus.vec_sel = state_q == LOAD_B;
  assign bus.vec_addr = addr_q;
  assign bus.result = result_q;
  assign bus.busy = state_q != IDLE && state_q != FINISH;
  assign bus.done = state_q == FINISH;
  uart_byte_sender u_tx (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .req_i      (req),
    .byte_i     (byte_s),
    .tx_busy_i  (bus.tx_busy),
    .ack_o      (ack),
    .tx_start_o (bus.tx_start),
    .tx_data_o  (bus.tx_data)
  );
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q <= LD_FETCH;
      mode_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sh_q <= '0;
      result_q <= '0;
      cnt_q <= '0;
`ifdef HOST_TIMEOUT_EN
      tmo_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sh_q <= sh_d;
      result_q <= result_d;
      cnt_q <= cnt_d;
`ifdef HOST_TIMEOUT_EN
      tmo_q <= tmo_d;
      err_q <= err_d;
`endif
    end
  end
  // Element fetch runs FETCH (vec_en) -> CAPT (register vec_data) -> LO -> HI byte.
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    mode_d = mode_q;
    addr_d = addr_q;
    data_d = data_q;
    sh_d = sh_q;
    result_d = result_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CMD_A;
        mode_d = bus.mode;
      end
      CMD_A, CMD_B: if (ack) begin
        state_d = state_q == CMD_A ? LOAD_A : LOAD_B;
        addr_d = '0;
        ph_d = LD_FETCH;
      end
      LOAD_A, LOAD_B: case (ph_q)
        LD_FETCH: ph_d = LD_CAPT;
        LD_CAPT: begin
          data_d = bus.vec_data;
          ph_d = LD_LO;
        end
        LD_LO: ph_d = ack ? LD_HI : LD_LO;
        default: if (ack) begin
          ph_d = LD_FETCH;
          addr_d = addr_q == LAST ? addr_q : addr_q + 10'd1;
          state_d = addr_q != LAST ? state_q : state_q == LOAD_A ? CMD_B : CMD_OP;
        end
      endcase
      CMD_OP: if (ack) begin
        state_d = RECV;
        cnt_d = '0;
      end
      RECV: if (bus.rx_ready) begin
        sh_d = {sh_q[15:0], bus.rx_data};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(RESULT_BYTES - 1)) begin
          state_d = FINISH;
          result_d = {sh_q, bus.rx_data};
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef HOST_TIMEOUT_EN
    err_d = (state_q == IDLE && bus.start) ? 1'b0 : err_q;
    tmo_d = (state_q == RECV && !bus.rx_ready) ? tmo_q + 1'b1 : '0;
    if (state_q == RECV && !bus.rx_ready && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
`endif
  end
endmodule

// File: tb/tb_coproc_host_driver.sv
// tb_coproc_host_driver: directed jobs against a vector memory and UART model, TX/result scoreboards.
module tb_coproc_host_driver;
  localparam int N = 4;
  localparam int TMO = 1000;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  coproc_host_driver_if bus();
  coproc_host_driver #(.N(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );
  always #5 clk_sys = ~clk_sys;
  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  logic [7:0] tx_q [$];
  logic [31:0] res_q [$];
  int n_pass = 0, n_fail = 0;
  int tx_cnt = 0, done_cnt = 0, busy_len = 3, busy_ctr = 0;
  logic prev_start = 1'b0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk_sys)
    if (bus.vec_en) bus.vec_data <= bus.vec_sel ? mem_b[bus.vec_addr[1:0]] : mem_a[bus.vec_addr[1:0]];
  // UART model and monitors: busy for busy_len cycles after each tx_start.
  always @(negedge clk_sys) begin
    if (bus.tx_start) begin
      check("tx_pulse_width", 32'(prev_start), 0);
      check("tx_busy_at_start", 32'(bus.tx_busy), 0);
      check("tx_expected", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) check("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      tx_cnt++;
      busy_ctr = busy_len;
    end else if (busy_ctr > 0) busy_ctr--;
    bus.tx_busy = busy_ctr > 0;
    prev_start = bus.tx_start;
    if (bus.done) begin
      done_cnt++;
      check("done_expected", 32'(res_q.size() != 0), 1);
      if (res_q.size() != 0) check("result", bus.result, res_q.pop_front());
    end
  end
  task automatic push_job(input logic m, input logic [31:0] res);
    tx_q.push_back(8'h01);
    for (int i = 0; i < N; i++) begin
      tx_q.push_back(mem_a[i][7:0]);
      tx_q.push_back(mem_a[i][15:8]);
    end
    tx_q.push_back(8'h02);
    for (int i = 0; i < N; i++) begin
      tx_q.push_back(mem_b[i][7:0]);
      tx_q.push_back(mem_b[i][15:8]);
    end
    tx_q.push_back(m ? 8'h07 : 8'h06);
    res_q.push_back(res);
  endtask
  task automatic pulse_start(input logic m);
    @(negedge clk_sys);
    bus.start = 1'b1;
    bus.mode = m;
    @(negedge clk_sys);
    bus.start = 1'b0;
  endtask
  task automatic send_rx(input logic [7:0] b);
    @(negedge clk_sys);
    bus.rx_data = b;
    bus.rx_ready = 1'b1;
    @(negedge clk_sys);
    bus.rx_ready = 1'b0;
  endtask
  task automatic wait_drain(input int budget);
    int c = 0;
    while (tx_q.size() != 0 && c < budget) begin
      @(negedge clk_sys);
      c++;
    end
    check("tx_drain_in_time", tx_q.size(), 0);
  endtask
  task automatic wait_res(input int budget);
    int c = 0;
    while (res_q.size() != 0 && c < budget) begin
      @(negedge clk_sys);
      c++;
    end
    check("done_in_time", res_q.size(), 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({bus.tx_start, bus.vec_en, bus.vec_sel, bus.busy, bus.done, bus.err_timeout}), 0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    check({tag, "_vec_addr"}, 32'(bus.vec_addr), 0);
    check({tag, "_result"}, bus.result, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, c0, c;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.rx_data = '0;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("reset");
    reset = 1'b0;
    // Dot product job, then spurious rx_ready in IDLE.
    mem_a = '{16'd1, 16'd2, 16'd3, 16'd4};
    mem_b = '{16'd5, 16'd6, 16'd7, 16'd8};
    send_rx(8'hFF);
    d0 = done_cnt; c0 = tx_cnt;
    push_job(1'b0, 32'h0000_0046);
    pulse_start(1'b0);
    check("busy_after_start", 32'(bus.busy), 1);
    wait_drain(5000);
    send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h46);
    wait_res(100);
    repeat (5) @(negedge clk_sys);
    check("dot_done_pulses", done_cnt - d0, 1);
    check("dot_tx_count", tx_cnt - c0, 19);
    check("dot_busy_after_done", 32'(bus.busy), 0);
    // Distance job, slow UART, first RX byte coincides with the op byte pulse.
    busy_len = 100;
    mem_a = '{16'h1234, 16'h0011, 16'h2233, 16'h4455};
    mem_b = '{16'h5566, 16'h7788, 16'h99AA, 16'hBBCC};
    d0 = done_cnt; c0 = tx_cnt;
    push_job(1'b1, 32'hDEAD_BEEF);
    pulse_start(1'b1);
    c = 0;
    while (!(bus.tx_start && bus.tx_data == 8'h07) && c < 5000) begin
      @(negedge clk_sys);
      c++;
    end
    check("op_byte_seen", 32'(c < 5000), 1);
    bus.rx_data = 8'hDE;
    bus.rx_ready = 1'b1;
    @(negedge clk_sys);
    bus.rx_ready = 1'b0;
    send_rx(8'hAD); send_rx(8'hBE);
    check("result_hold", bus.result, 32'h0000_0046);
    send_rx(8'hEF);
    wait_res(100);
    repeat (5) @(negedge clk_sys);
    check("dist_done_pulses", done_cnt - d0, 1);
    check("dist_tx_count", tx_cnt - c0, 19);
    // Restart and rx_ready while loading are ignored.
    busy_len = 3;
    d0 = done_cnt; c0 = tx_cnt;
    push_job(1'b0, 32'h0102_0304);
    pulse_start(1'b0);
    send_rx(8'hFF);
    c = 0;
    while (!bus.vec_sel && c < 2000) begin
      @(negedge clk_sys);
      c++;
    end
    check("reached_load_b", 32'(bus.vec_sel), 1);
    pulse_start(1'b1);
    send_rx(8'hFF);
    wait_drain(5000);
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    wait_res(100);
    repeat (20) @(negedge clk_sys);
    check("restart_tx_count", tx_cnt - c0, 19);
    check("restart_done_pulses", done_cnt - d0, 1);
    // Only two result bytes arrive.
    d0 = done_cnt;
    push_job(1'b0, 32'h0);
    void'(res_q.pop_back());
    pulse_start(1'b0);
    wait_drain(5000);
    send_rx(8'h11); send_rx(8'h22);
`ifdef HOST_TIMEOUT_EN
    c = 0;
    while (!bus.err_timeout && c < 2000) begin
      @(negedge clk_sys);
      c++;
    end
    check("timeout_cycles", c, TMO);
    check("timeout_busy_low", 32'(bus.busy), 0);
    repeat (10) @(negedge clk_sys);
    check("timeout_sticky", 32'(bus.err_timeout), 1);
    check("timeout_no_done", done_cnt - d0, 0);
`else
    res_q.push_back(32'h1122_3344);
    repeat (1200) @(negedge clk_sys);
    check("no_timeout_err", 32'(bus.err_timeout), 0);
    check("recv_still_busy", 32'(bus.busy), 1);
    send_rx(8'h33); send_rx(8'h44);
    wait_res(100);
    check("late_done_pulses", done_cnt - d0, 1);
`endif
    // Reset in the middle of LOAD_A.
    mem_a = '{16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2};
    c0 = tx_cnt;
    push_job(1'b0, 32'h0);
    pulse_start(1'b0);
    check("err_cleared_by_start", 32'(bus.err_timeout), 0);
    c = 0;
    while (tx_cnt - c0 < 4 && c < 2000) begin
      @(negedge clk_sys);
      c++;
    end
    check("in_load_a", 32'({bus.vec_sel, bus.busy}), 32'b01);
    reset = 1'b1;
    @(negedge clk_sys);
    check_reset_outputs("midjob_reset");
    tx_q.delete();
    res_q.delete();
    reset = 1'b0;
    c0 = tx_cnt;
    repeat (300) @(negedge clk_sys);
    check("no_tx_after_reset", tx_cnt - c0, 0);
    check("idle_after_reset", 32'(bus.busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule

// File: doc/coproc_host_driver.md
COPROC_HOST_DRIVER -- requirements
Module: coproc_host_driver

Interface
REQ-001 Parameter N, default 1024: number of 16-bit elements per vector.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000: result-reception watchdog limit in clk_sys cycles.
REQ-003 clk_sys  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a full job when idle.
REQ-006 mode  input  1  operation select: 0 = dot product (cmd 6), 1 = Euclidean distance (cmd 7); sampled at start.
REQ-007 vec_en  output  1  read enable to source vector memory.
REQ-008 vec_sel  output  1  0 = vector A, 1 = vector B.
REQ-009 vec_addr  output  10  element address.
REQ-010 vec_data  input  16  element data, valid 1 cycle after vec_en.
REQ-011 tx_data  output  8  byte to UART transmitter.
REQ-012 tx_start  output  1  one-cycle transmit request.
REQ-013 tx_busy  input  1  UART transmitter busy.
REQ-014 rx_data  input  8  received byte.
REQ-015 rx_ready  input  1  one-cycle received-byte strobe.
REQ-016 result  output  32  assembled coprocessor result.
REQ-017 busy  output  1  high from accepted start until done or error.
REQ-018 done  output  1  one-cycle pulse when result is valid.
REQ-019 err_timeout  output  1  sticky timeout flag, cleared by the next accepted start.

Function
REQ-020 The module SHALL run states IDLE, CMD_A, LOAD_A, CMD_B, LOAD_B, CMD_OP, RECV, FINISH, in that order.
REQ-021 start SHALL be accepted only in IDLE; it SHALL be ignored while busy.
REQ-022 The command bytes SHALL be: CMD_A = 0x01, CMD_B = 0x02, CMD_OP = 0x06 or 0x07 per latched mode.
REQ-023 LOAD_A and LOAD_B SHALL send 2*N bytes; each element is sent low byte first, then high byte; addresses run 0..N-1.
REQ-024 The byte handshake SHALL be: tx_start is pulsed for exactly one cycle only when tx_busy=0; the next pulse requires tx_busy to be seen high and then low.
REQ-025 The element fetch SHALL assert vec_en one cycle before the low byte is needed; vec_data SHALL be registered and held for both bytes.
REQ-026 The address counter SHALL reset to 0 on entry to LOAD_A and LOAD_B; leaving the state after address N-1 SHALL NOT wrap into a resend.
REQ-027 RECV SHALL capture 4 bytes on rx_ready, MSB first, into a shift register; rx_ready SHALL be ignored in every other state.
REQ-028 FINISH SHALL update result, pulse done for one cycle, drop busy, and return to IDLE; result SHALL hold until the next FINISH.
REQ-029 If rx_ready and tx_start coincide in the same cycle, both SHALL be honoured independently.

Reset
REQ-030 On reset: state = IDLE, tx_start = 0, tx_data = 0, vec_en = 0, vec_sel = 0, vec_addr = 0, result = 0, busy = 0, done = 0, err_timeout = 0.
REQ-031 A reset mid-job SHALL abort the job immediately; no further tx_start SHALL be issued.

Configuration
REQ-032 With macro HOST_TIMEOUT_EN defined, a counter SHALL run in RECV and reset on each rx_ready; when it reaches TIMEOUT_CYCLES the module SHALL set err_timeout, drop busy, skip done, and return to IDLE.
REQ-033 Without HOST_TIMEOUT_EN, RECV SHALL wait indefinitely and err_timeout SHALL be tied to 0.

Structure
REQ-034 A shared package SHALL hold the state enum, the command constants (0x01, 0x02, 0x06, 0x07), and RESULT_BYTES = 4.
REQ-035 One sub-module, uart_byte_sender, SHALL implement the REQ-024 byte handshake (byte in, req/ack, tx_start/tx_busy).

Verification
REQ-036 N=4, A={1,2,3,4}, B={5,6,7,8}, mode=0 -> TX stream 01,01,00,02,00,03,00,04,00,02,05,00,06,00,07,00,08,00,06; RX 00,00,00,46 -> result=0x00000046 with a single done pulse.
REQ-037 mode=1, element 0x1234 -> its bytes are sent as 34 then 12; command byte 07; RX DE,AD,BE,EF -> result=0xDEADBEEF.
REQ-038 tx_busy held high for 100 cycles after each byte -> exactly one tx_start per byte, with no overlap.
REQ-039 start pulsed again in LOAD_B -> the pulse is ignored and the TX byte count is unchanged.
REQ-040 HOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=1000, only 2 RX bytes -> err_timeout=1 at cycle 1000 after the last byte, no done pulse, state returns to IDLE.
REQ-041 reset asserted during LOAD_A -> all outputs take their reset values on the next edge and no further tx_start is issued.
